// File: rtl/barrel_shift_sched.sv
// barrel_shift_sched: two-client round-robin scheduler sharing one
// rotate-left datapath. Rotations are applied in passes of up to 3 bit
// positions per cycle; the result is returned with the client id.
module barrel_shift_sched #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   input  logic [AMT_W-1:0] req0_amt,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   input  logic [AMT_W-1:0] req1_amt,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_id,
   input  logic             out_ready,
   output logic             busy
);

   localparam logic [AMT_W-1:0] MAX_STEP = AMT_W'(3);

   typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [AMT_W-1:0] rem;
   logic             cur_id;
   logic             last_grant;

   logic             grant_any;
   logic             grant_id;
   logic             accept;
   logic [AMT_W-1:0] step;
   logic [AMT_W-1:0] rem_next;
   logic [WIDTH-1:0] rot;

   // Arbitration: a lone requester wins; on a tie the client not served last wins.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      grant_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant;
      end else begin
         grant_id = req1_valid;
      end
   end

   // Ready only toward the granted client while idle, and never during reset.
   assign req0_ready = reset && (state == IDLE) && grant_any && !grant_id;
   assign req1_ready = reset && (state == IDLE) && grant_any &&  grant_id;
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   // One rotation pass: step = min(rem, 3), applied as repeated single-bit rotates.
   always_comb begin
      step = (rem > MAX_STEP) ? MAX_STEP : rem;
      rem_next = rem - step;
      rot = work;
      for (int unsigned i = 0; i < 3; i++) begin
         if (i < 32'(step)) begin
            rot = {rot[WIDTH-2:0], rot[WIDTH-1]};
         end
      end
   end

   // Scheduler FSM with registered result, id, valid and busy outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         work       <= '0;
         rem        <= '0;
         cur_id     <= 1'b0;
         last_grant <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_id     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  work       <= grant_id ? req1_data : req0_data;
                  rem        <= grant_id ? req1_amt  : req0_amt;
                  cur_id     <= grant_id;
                  last_grant <= grant_id;
                  busy       <= 1'b1;
                  state      <= ROTATE;
               end
            end
            ROTATE: begin
               work <= rot;
               rem  <= rem_next;
               if (rem_next == '0) begin
                  out_valid <= 1'b1;
                  out_data  <= rot;
                  out_id    <= cur_id;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_barrel_shift_sched.sv
// Directed testbench for barrel_shift_sched (WIDTH=4, AMT_W=4).
module tb_barrel_shift_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid;
   logic [3:0] req0_data, req1_data;
   logic [3:0] req0_amt, req1_amt;
   logic       req0_ready, req1_ready;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_id;
   logic       out_ready;
   logic       busy;

   int total = 0;
   int bad   = 0;

   barrel_shift_sched #(.WIDTH(4), .AMT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_amt   (req0_amt),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_amt   (req1_amt),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_id     (out_id),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One complete transaction for a client with out_ready held high.
   task automatic run_op(input logic id, input logic [3:0] d, input logic [3:0] a,
                         input int k, input logic [3:0] exp);
      if (id) begin
         req1_valid = 1'b1; req1_data = d; req1_amt = a;
      end else begin
         req0_valid = 1'b1; req0_data = d; req0_amt = a;
      end
      #1;
      chk1("ready_granted", id ? req1_ready : req0_ready, 1'b1);
      chk1("ready_other",   id ? req0_ready : req1_ready, 1'b0);
      tick();
      if (id) begin
         req1_valid = 1'b0; req1_data = ~d; req1_amt = 4'd7;
      end else begin
         req0_valid = 1'b0; req0_data = ~d; req0_amt = 4'd7;
      end
      chk1("busy_after_accept", busy, 1'b1);
      chk1("ready0_rotate", req0_ready, 1'b0);
      for (int i = 1; i < k; i++) begin
         tick();
         chk1("no_valid_mid_rotate", out_valid, 1'b0);
      end
      tick();
      chk1("out_valid_done", out_valid, 1'b1);
      chk4("out_data", out_data, exp);
      chk1("out_id", out_id, id);
      tick();
      chk1("out_valid_cleared", out_valid, 1'b0);
      chk1("busy_cleared", busy, 1'b0);
      chk4("out_data_held", out_data, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      req0_valid = 1'b1; req0_data = 4'b1001; req0_amt = 4'd1;
      req1_valid = 1'b0; req1_data = 4'b0000; req1_amt = 4'd0;
      out_ready = 1'b1;
      tick();
      tick();
      chk1("rst_out_valid", out_valid, 1'b0);
      chk4("rst_out_data", out_data, 4'b0000);
      chk1("rst_out_id", out_id, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_req0_ready", req0_ready, 1'b0);
      chk1("rst_req1_ready", req1_ready, 1'b0);
      req0_valid = 1'b0;
      reset = 1'b1;

      // Single pass, multi pass, zero count
      run_op(1'b0, 4'b1001, 4'd1, 1, 4'b0011);
      run_op(1'b1, 4'b1001, 4'd5, 2, 4'b0011);
      run_op(1'b0, 4'b1010, 4'd0, 1, 4'b1010);

      // Round-robin with both clients valid from reset release
      reset = 1'b0;
      req0_valid = 1'b1; req0_data = 4'h1; req0_amt = 4'd0;
      req1_valid = 1'b1; req1_data = 4'h2; req1_amt = 4'd0;
      tick();
      reset = 1'b1;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk1("rr_ready0", req0_ready, (g % 2) == 0);
         chk1("rr_ready1", req1_ready, (g % 2) == 1);
         tick();
         chk1("rr_ready0_rot", req0_ready, 1'b0);
         chk1("rr_ready1_rot", req1_ready, 1'b0);
         tick();
         chk1("rr_out_valid", out_valid, 1'b1);
         chk1("rr_out_id", out_id, (g % 2) == 1);
         chk4("rr_out_data", out_data, ((g % 2) == 1) ? 4'h2 : 4'h1);
         chk1("rr_ready0_done", req0_ready, 1'b0);
         chk1("rr_ready1_done", req1_ready, 1'b0);
         tick();
         chk1("rr_out_cleared", out_valid, 1'b0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;

      // Backpressure in DONE; last grant was client 1, so client 0 goes first
      out_ready = 1'b0;
      req0_valid = 1'b1; req0_data = 4'b1010; req0_amt = 4'd0;
      #1;
      chk1("bp_ready0", req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_data = 4'b0110; req1_amt = 4'd2;
      tick();
      chk1("bp_out_valid", out_valid, 1'b1);
      chk4("bp_out_data", out_data, 4'b1010);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("bp_hold_valid", out_valid, 1'b1);
         chk4("bp_hold_data", out_data, 4'b1010);
         chk1("bp_hold_id", out_id, 1'b0);
         chk1("bp_hold_ready0", req0_ready, 1'b0);
         chk1("bp_hold_ready1", req1_ready, 1'b0);
         chk1("bp_hold_busy", busy, 1'b1);
      end
      out_ready = 1'b1;
      #1;
      chk1("bp_ready1_same_cycle", req1_ready, 1'b0);
      tick();
      chk1("bp_released_valid", out_valid, 1'b0);
      chk1("bp_released_busy", busy, 1'b0);
      chk4("bp_released_data", out_data, 4'b1010);
      chk1("bp_next_ready1", req1_ready, 1'b1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk1("bp2_out_valid", out_valid, 1'b1);
      chk4("bp2_out_data", out_data, 4'b1001);
      chk1("bp2_out_id", out_id, 1'b1);
      tick();

      // Async reset during the 2nd ROTATE cycle of an amt-15 operation
      req0_valid = 1'b1; req0_data = 4'b1001; req0_amt = 4'd15;
      req1_valid = 1'b1; req1_data = 4'b0100; req1_amt = 4'd1;
      #1;
      chk1("ar_ready0", req0_ready, 1'b1);
      tick();
      tick();
      chk1("ar_busy_pre", busy, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk1("ar_out_valid", out_valid, 1'b0);
      chk4("ar_out_data", out_data, 4'b0000);
      chk1("ar_out_id", out_id, 1'b0);
      chk1("ar_busy", busy, 1'b0);
      chk1("ar_req0_ready", req0_ready, 1'b0);
      chk1("ar_req1_ready", req1_ready, 1'b0);
      tick();
      reset = 1'b1;
      run_op(1'b0, 4'b1001, 4'd15, 5, 4'b1100);
      req1_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
